// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: round-robin grant, one transaction in flight,
// sub-word loads with sign/zero extension and sub-word stores via read-modify-write.
module dmem_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned DATA_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [DATA_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    input  logic [1:0]        r0_size,
    input  logic              r0_sext,
    output logic              r0_gnt,
    output logic              r0_rvalid,
    output logic [DATA_W-1:0] r0_rdata,
    output logic              r0_err,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [DATA_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    input  logic [1:0]        r1_size,
    input  logic              r1_sext,
    output logic              r1_gnt,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              r1_err,
    output logic [DATA_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned OwnerW = $clog2(NUM_REQ);

    typedef enum logic [2:0] {IDLE, RD, RDWAIT, WR, RESP} arbStateT;

    arbStateT          state, stateNext;
    logic [OwnerW-1:0] lastGnt, ownerQ;
    logic [DATA_W-1:0] addrQ, wordQ, respQ;
    logic              weQ, sextQ, errQ;
    logic [1:0]        sizeQ;

    logic              pick0, pick1, anyReq;
    logic              selWe, selSext, selErr;
    logic [DATA_W-1:0] selAddr, selWdata;
    logic [1:0]        selSize;
    logic [DATA_W-1:0] alignedAddr, loadData, merged, mask, ins;
    logic [4:0]        byteShift, halfShift;
    logic [7:0]        byteVal;
    logic [15:0]       halfVal;

    // Round-robin pick and mux of the winning requester's fields
    always_comb begin
        anyReq   = r0_req | r1_req;
        pick0    = r0_req & (~r1_req | (lastGnt != '0));
        pick1    = r1_req & ~pick0;
        selWe    = pick1 ? r1_we    : r0_we;
        selAddr  = pick1 ? r1_addr  : r0_addr;
        selWdata = pick1 ? r1_wdata : r0_wdata;
        selSize  = pick1 ? r1_size  : r0_size;
        selSext  = pick1 ? r1_sext  : r0_sext;
        unique case (selSize)
            2'b00:   selErr = 1'b0;
            2'b01:   selErr = selAddr[0];
            2'b10:   selErr = |selAddr[1:0];
            default: selErr = 1'b1;
        endcase
    end

    // Lane extraction for loads and lane merge for sub-word stores
    always_comb begin
        byteShift = {addrQ[1:0], 3'b000};
        halfShift = {addrQ[1], 4'b0000};
        byteVal   = mem_rdata[byteShift +: 8];
        halfVal   = mem_rdata[halfShift +: 16];
        unique case (sizeQ)
            2'b00: begin
                loadData = {{(DATA_W-8){sextQ & byteVal[7]}}, byteVal};
                mask     = DATA_W'(8'hFF) << byteShift;
                ins      = DATA_W'(wordQ[7:0]) << byteShift;
            end
            2'b01: begin
                loadData = {{(DATA_W-16){sextQ & halfVal[15]}}, halfVal};
                mask     = DATA_W'(16'hFFFF) << halfShift;
                ins      = DATA_W'(wordQ[15:0]) << halfShift;
            end
            default: begin
                loadData = mem_rdata;
                mask     = '1;
                ins      = wordQ;
            end
        endcase
        merged      = (mem_rdata & ~mask) | (ins & mask);
        alignedAddr = {addrQ[DATA_W-1:2], 2'b00};
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= stateNext;
    end

    // Next-state logic and all interface outputs
    always_comb begin
        stateNext = state;
        r0_gnt    = 1'b0;
        r1_gnt    = 1'b0;
        r0_rvalid = 1'b0;
        r1_rvalid = 1'b0;
        r0_rdata  = '0;
        r1_rdata  = '0;
        r0_err    = 1'b0;
        r1_err    = 1'b0;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        unique case (state)
            IDLE: begin
                // grants are combinational, so gate them to keep outputs at 0 during reset
                r0_gnt = pick0 & rst_n;
                r1_gnt = pick1 & rst_n;
                if (anyReq) begin
                    if (selErr)                         stateNext = RESP;
                    else if (selWe && selSize == 2'b10) stateNext = WR;
                    else                                stateNext = RD;
                end
            end
            RD: begin
                mem_addr  = alignedAddr;
                stateNext = RDWAIT;
            end
            RDWAIT: begin
                mem_addr  = alignedAddr;
                stateNext = weQ ? WR : RESP;
            end
            WR: begin
                mem_addr  = alignedAddr;
                mem_we    = 1'b1;
                mem_wdata = wordQ;
                stateNext = RESP;
            end
            RESP: begin
                if (ownerQ == '0) begin
                    r0_rvalid = 1'b1;
                    r0_rdata  = respQ;
                    r0_err    = errQ;
                end else begin
                    r1_rvalid = 1'b1;
                    r1_rdata  = respQ;
                    r1_err    = errQ;
                end
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // Request latch at grant; read-word capture as load result or merged store word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lastGnt <= OwnerW'(1);
            ownerQ  <= '0;
            addrQ   <= '0;
            wordQ   <= '0;
            respQ   <= '0;
            weQ     <= 1'b0;
            sextQ   <= 1'b0;
            errQ    <= 1'b0;
            sizeQ   <= '0;
        end else if (state == IDLE && anyReq) begin
            lastGnt <= pick1 ? OwnerW'(1) : '0;
            ownerQ  <= pick1 ? OwnerW'(1) : '0;
            addrQ   <= selAddr;
            wordQ   <= selWdata;
            respQ   <= '0;
            weQ     <= selWe;
            sextQ   <= selSext;
            errQ    <= selErr;
            sizeQ   <= selSize;
        end else if (state == RDWAIT) begin
            if (weQ) wordQ <= merged;
            else     respQ <= loadData;
        end
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: NUM_REQ, 2, number of requesters (fixed at 2 for this revision).
REQ-002 Parameter: DATA_W, 32, data and address width.
REQ-003 Port: clk  input  1  single clock, all state on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Ports, N in {0,1}: rN_req  input  1  request held until granted.
REQ-006 Ports: rN_we  input  1  1=store, 0=load.
REQ-007 Ports: rN_addr  input  32  byte address.
REQ-008 Ports: rN_wdata  input  32  store data, low bytes used for sub-word stores.
REQ-009 Ports: rN_size  input  2  00=byte, 01=half, 10=word, 11=reserved.
REQ-010 Ports: rN_sext  input  1  sign-extend sub-word loads.
REQ-011 Ports: rN_gnt  output  1  one-cycle grant; request fields sampled this cycle.
REQ-012 Ports: rN_rvalid  output  1  one-cycle completion, for loads and stores.
REQ-013 Ports: rN_rdata  output  32  load result, valid with rN_rvalid.
REQ-014 Ports: rN_err  output  1  misaligned or reserved size, valid with rN_rvalid.
REQ-015 Port: mem_addr  output  32  word-aligned RAM address, bits [1:0] = 0.
REQ-016 Port: mem_we  output  1  RAM write enable.
REQ-017 Port: mem_wdata  output  32  full-word RAM write data.
REQ-018 Port: mem_rdata  input  32  RAM read data, valid one cycle after mem_addr.

Function
REQ-019 FSM states: IDLE, RD, RDWAIT, WR, RESP; one transaction in flight.
REQ-020 IDLE with any rN_req: exactly one rN_gnt=1 that cycle; latch addr, we, wdata, size, sext, owner.
REQ-021 Arbitration is round-robin. On simultaneous requests, grant the requester not granted last. A lone request is granted regardless of the pointer.
REQ-022 From IDLE: error -> RESP; word store -> WR; load or sub-word store -> RD.
REQ-023 RD: mem_addr = {addr[31:2],2'b00}, mem_we=0; next state RDWAIT.
REQ-024 RDWAIT: capture mem_rdata. Load -> RESP with extracted data. Sub-word store -> WR with merged word.
REQ-025 WR: mem_we=1 for exactly one cycle; mem_wdata = merged word or full wdata; next state RESP.
REQ-026 RESP: owner's rN_rvalid=1 for one cycle with rdata/err; next state IDLE. No grant is issued in RESP.
REQ-027 Latency from grant cycle T to rvalid:
- load: T+3
- word store: T+2
- sub-word store: T+4
- error: T+1
REQ-028 Byte load: lane = addr[1:0]*8. Half load: lane = addr[1]*16. Upper bits are sign-extended if sext, else zeroed.
REQ-029 Byte store replaces only lane addr[1:0] with wdata[7:0]. Half store replaces only lane addr[1] with wdata[15:0]. Other bytes are kept from the read word.
REQ-030 Error conditions: half with addr[0]=1, word with addr[1:0]!=0, or size=11. In each case: no RAM access, rdata=0, err=1.
REQ-031 Outside RESP, all rN_rvalid, rN_err and rN_rdata are 0. mem_we=0 outside WR. mem_addr and mem_wdata are 0 in IDLE.
REQ-032 A request deasserted before grant is dropped with no side effect. Requests arriving during a transaction wait in their requester.
REQ-033 Store completion (rvalid) is never signalled before its RAM write cycle.

Reset
REQ-034 rst_n=0 forces, asynchronously: state=IDLE, all outputs 0, latched request fields 0, round-robin pointer set so r0 wins the first contention.
REQ-035 Reset during any state aborts the transaction. mem_we drops immediately, no rvalid is issued, and a partial RMW is never written.

Verification
REQ-036 Bench SHALL cover:
- r0 load word addr 0x10, RAM[0x10]=0xDEADBEEF -> r0_rvalid at T+3, rdata 0xDEADBEEF, err 0.
- r1 byte store 0xAB at addr 0x13 over RAM[0x10]=0x11223344 -> single mem_we at T+3 with wdata 0xAB223344; r1_rvalid at T+4.
- Byte load addr 0x12 of 0x0080FF00, sext=1 -> 0xFFFFFF80; sext=0 -> 0x00000080.
- r0 and r1 request continuously -> grants alternate r0, r1, r0, ...; no overlap of transactions.
- r0 half store addr 0x21 -> rvalid at T+1 with err=1, rdata 0, mem_we never asserted.
- rst_n low during WR of a sub-word store -> mem_we falls immediately, no rvalid, next grant after release goes to r0 under contention.
